// File: rtl/bcd_key_entry.sv
// Keypad operand entry: scans a 4x4 matrix, debounces whole frames and shifts digits into BCD operands A/B.
// Optional BCD_KEY_BACKSPACE_EN makes '#' delete the last entered digit.
module bcd_key_entry #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] col_out,
  input  logic [3:0] row_in,
  output logic [3:0] a0,
  output logic [3:0] a1,
  output logic [3:0] a2,
  output logic [3:0] a3,
  output logic [3:0] b0,
  output logic [3:0] b1,
  output logic [3:0] b2,
  output logic [3:0] b3,
  output logic       sel_b,
  output logic       operands_valid,
  output logic       key_strobe
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);
  // Frame result code: {hit, row[1:0], col[1:0]}; all-zero means no key.
  localparam logic [4:0] NONE = 5'd0;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    DONE    = 2'd2
  } state_t;

  // ---------------- scanner ----------------
  logic [DW-1:0] div_q;
  logic [1:0]    col_q;
  logic          tick;
  logic          frame_end;

  assign tick      = (div_q == DW'(SCAN_DIV - 1));
  assign frame_end = tick && (col_q == 2'd3);
  assign col_out   = ~(4'b0001 << col_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      col_q <= 2'd0;
    end else if (tick) begin
      div_q <= '0;
      col_q <= col_q + 2'd1;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  // Lowest pressed row in the currently driven column.
  logic       row_hit;
  logic [1:0] row_idx;
  always_comb begin
    row_hit = 1'b0;
    row_idx = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_in[r]) begin
        row_hit = 1'b1;
        row_idx = 2'(r);
      end
    end
  end

  logic       frame_hit_q;
  logic [3:0] frame_key_q;
  logic [4:0] res;

  // Earlier columns win, so a captured key is never overwritten within a frame.
  always_comb begin
    res = NONE;
    if (frame_hit_q)  res = {1'b1, frame_key_q};
    else if (row_hit) res = {1'b1, row_idx, col_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_hit_q <= 1'b0;
      frame_key_q <= 4'd0;
    end else if (frame_end) begin
      frame_hit_q <= 1'b0;
      frame_key_q <= 4'd0;
    end else if (tick && !frame_hit_q && row_hit) begin
      frame_hit_q <= 1'b1;
      frame_key_q <= {row_idx, col_q};
    end
  end

  // ---------------- debounce ----------------
  logic [4:0]    deb_q;
  logic [4:0]    cand_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] run;
  logic          accept;
  logic          press;

  assign run    = (res == cand_q) ? cnt_q + CW'(1) : CW'(1);
  assign accept = frame_end && (res != deb_q) && (run >= CW'(DEBOUNCE));
  // Only a release-to-key change counts; key-to-key swaps just move the debounced state.
  assign press  = accept && (deb_q == NONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q  <= NONE;
      cand_q <= NONE;
      cnt_q  <= '0;
    end else if (frame_end) begin
      cand_q <= res;
      if (res == deb_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        deb_q <= res;
        cnt_q <= '0;
      end else begin
        cnt_q <= run;
      end
    end
  end

  // ---------------- key decode ----------------
  logic       is_digit;
  logic [3:0] digit;
  logic       is_plus;
  logic       is_eq;
  logic       is_clr;
`ifdef BCD_KEY_BACKSPACE_EN
  logic       is_back;
`endif

  always_comb begin
    is_digit = 1'b0;
    digit    = 4'd0;
    is_plus  = 1'b0;
    is_eq    = 1'b0;
    is_clr   = 1'b0;
`ifdef BCD_KEY_BACKSPACE_EN
    is_back  = 1'b0;
`endif
    case (res[3:0])
      4'b0000: begin is_digit = 1'b1; digit = 4'd1; end
      4'b0001: begin is_digit = 1'b1; digit = 4'd2; end
      4'b0010: begin is_digit = 1'b1; digit = 4'd3; end
      4'b0011: is_plus = 1'b1;
      4'b0100: begin is_digit = 1'b1; digit = 4'd4; end
      4'b0101: begin is_digit = 1'b1; digit = 4'd5; end
      4'b0110: begin is_digit = 1'b1; digit = 4'd6; end
      4'b0111: is_eq = 1'b1;
      4'b1000: begin is_digit = 1'b1; digit = 4'd7; end
      4'b1001: begin is_digit = 1'b1; digit = 4'd8; end
      4'b1010: begin is_digit = 1'b1; digit = 4'd9; end
      4'b1011: is_clr = 1'b1;
      4'b1101: begin is_digit = 1'b1; digit = 4'd0; end
`ifdef BCD_KEY_BACKSPACE_EN
      4'b1110: is_back = 1'b1;
`endif
      default: ;
    endcase
  end

  // ---------------- operand FSM ----------------
  state_t          state_q, state_d;
  logic [3:0][3:0] a_q, a_d;
  logic [3:0][3:0] b_q, b_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    if (press) begin
      if (is_clr) begin
        a_d     = '0;
        b_d     = '0;
        state_d = ENTER_A;
      end else if (is_digit) begin
        case (state_q)
          // A full operand (nonzero top digit) swallows further digits.
          ENTER_A: if (a_q[3] == 4'd0) a_d = {a_q[2:0], digit};
          ENTER_B: if (b_q[3] == 4'd0) b_d = {b_q[2:0], digit};
          DONE: begin
            a_d     = {12'd0, digit};
            b_d     = '0;
            state_d = ENTER_A;
          end
          default: state_d = ENTER_A;
        endcase
      end else if (is_plus) begin
        if (state_q == ENTER_A) begin
          state_d = ENTER_B;
        end else if (state_q == DONE) begin
          b_d     = '0;
          state_d = ENTER_B;
        end
      end else if (is_eq) begin
        if (state_q != DONE) state_d = DONE;
      end
`ifdef BCD_KEY_BACKSPACE_EN
      else if (is_back) begin
        if (state_q == ENTER_A) begin
          a_d = {4'd0, a_q[3:1]};
        end else begin
          b_d     = {4'd0, b_q[3:1]};
          state_d = ENTER_B;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ENTER_A;
      a_q        <= '0;
      b_q        <= '0;
      key_strobe <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      key_strobe <= press;
    end
  end

  assign a0 = a_q[0];
  assign a1 = a_q[1];
  assign a2 = a_q[2];
  assign a3 = a_q[3];
  assign b0 = b_q[0];
  assign b1 = b_q[1];
  assign b2 = b_q[2];
  assign b3 = b_q[3];

  assign sel_b          = (state_q == ENTER_B);
  assign operands_valid = (state_q == DONE);

endmodule

// File: tb/tb_bcd_key_entry.sv
// Bench for bcd_key_entry: keypad model, frame/keystroke-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_bcd_key_entry;
  localparam int SD = 4;
  localparam int DB = 2;
  localparam int FR = 4 * SD;

  localparam int K1 = 0, K2 = 1, K3 = 2, KPLUS = 3, K4 = 4, K5 = 5, K6 = 6, KEQ = 7;
  localparam int K7 = 8, K8 = 9, K9 = 10, KCLR = 11, K0 = 13, KHASH = 14;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_out, row_in;
  logic [3:0] a0, a1, a2, a3, b0, b1, b2, b3;
  logic       sel_b, operands_valid, key_strobe;

  bcd_key_entry #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk(clk), .rst(rst), .col_out(col_out), .row_in(row_in),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .b0(b0), .b1(b1), .b2(b2), .b3(b3),
    .sel_b(sel_b), .operands_valid(operands_valid), .key_strobe(key_strobe)
  );

  always #5 clk = ~clk;

  // Physical keypad: one key (index row*4+col) or none.
  int pressed = -1;
  always_comb begin
    row_in = 4'hF;
    if (pressed >= 0 && col_out[pressed % 4] == 1'b0) row_in[pressed / 4] = 1'b0;
  end

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int strobes = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // ---------------- reference model ----------------
  int dig_tab [16] = '{1, 2, 3, -1, 4, 5, 6, -1, 7, 8, 9, -1, -1, 0, -1, -1};
  int ph, fhit, fkey, deb;
  int hist[$];
  int ma, mb, mst;        // mst: 0 enter A, 1 enter B, 2 done
  bit exp_strobe;

  task automatic apply_key(input int k);
    int d;
    d = dig_tab[k];
    if (k == KCLR) begin
      ma = 0; mb = 0; mst = 0;
    end else if (d >= 0) begin
      if (mst == 0) begin
        if (ma < 1000) ma = ma * 10 + d;
      end else if (mst == 1) begin
        if (mb < 1000) mb = mb * 10 + d;
      end else begin
        ma = d; mb = 0; mst = 0;
      end
    end else if (k == KPLUS) begin
      if (mst == 0) mst = 1;
      else if (mst == 2) begin mb = 0; mst = 1; end
    end else if (k == KEQ) begin
      mst = 2;
    end
`ifdef BCD_KEY_BACKSPACE_EN
    else if (k == KHASH) begin
      if (mst == 0) ma = ma / 10;
      else begin mb = mb / 10; mst = 1; end
    end
`endif
  endtask

  always @(posedge clk) begin
    if (rst) begin
      ph = 0; fhit = 0; fkey = -1; deb = -1;
      hist.delete();
      ma = 0; mb = 0; mst = 0;
      exp_strobe = 1'b0;
    end else begin
      exp_strobe = 1'b0;
      if (ph % SD == SD - 1) begin
        if (fhit == 0 && pressed >= 0 && pressed % 4 == ph / SD) begin
          fhit = 1; fkey = pressed;
        end
        if (ph == FR - 1) begin
          int r;
          bit same;
          r = (fhit != 0) ? fkey : -1;
          fhit = 0;
          hist.push_back(r);
          if (hist.size() > DB) void'(hist.pop_front());
          same = (hist.size() == DB);
          foreach (hist[i]) if (hist[i] != r) same = 1'b0;
          if (same && r != deb) begin
            if (deb < 0) begin
              exp_strobe = 1'b1;
              apply_key(r);
            end
            deb = r;
          end
        end
      end
      ph = (ph + 1) % FR;
    end
  end

  always @(negedge clk) begin
    if (key_strobe === 1'b1) strobes++;
    if (chk_en) begin
      logic [3:0] ecol;
      ecol = 4'hF;
      ecol[ph / SD] = 1'b0;
      check("col_out", col_out, ecol);
      check("key_strobe", key_strobe, exp_strobe);
      check("a_digits", {a3, a2, a1, a0}, bcd(ma));
      check("b_digits", {b3, b2, b1, b0}, bcd(mb));
      check("sel_b", sel_b, mst == 1);
      check("operands_valid", operands_valid, mst == 2);
    end
  end

  // ---------------- stimulus ----------------
  task automatic key(input int k, input int hold_frames);
    @(negedge clk);
    pressed = k;
    repeat (hold_frames * FR) @(negedge clk);
    pressed = -1;
    repeat (4 * FR) @(negedge clk);
  endtask

  task automatic tap(input int k);
    key(k, 4);
  endtask

  int s0;

  initial begin
    rst = 1'b1;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_col", col_out, 4'b1110);
    check("rst_a", {a3, a2, a1, a0}, 16'h0000);
    check("rst_b", {b3, b2, b1, b0}, 16'h0000);
    check("rst_sel_b", sel_b, 1'b0);
    check("rst_valid", operands_valid, 1'b0);
    check("rst_strobe", key_strobe, 1'b0);
    rst = 1'b0;
    repeat (4) @(posedge clk); @(negedge clk);
    check("col1", col_out, 4'b1101);
    repeat (4) @(posedge clk); @(negedge clk);
    check("col2", col_out, 4'b1011);
    repeat (4) @(posedge clk); @(negedge clk);
    check("col3", col_out, 4'b0111);

    // 123 + 45 =
    s0 = strobes;
    tap(K1); tap(K2); tap(K3); tap(KPLUS);
    check("plus_sel_b", sel_b, 1'b1);
    tap(K4); tap(K5); tap(KEQ);
    check("seq_strobes", strobes - s0, 7);
    check("seq_a", {a3, a2, a1, a0}, 16'h0123);
    check("seq_b", {b3, b2, b1, b0}, 16'h0045);
    check("seq_valid", operands_valid, 1'b1);
    check("model_a", ma, 123);
    check("model_b", mb, 45);

    // one-frame glitch is rejected, long hold gives exactly one press
    s0 = strobes;
    key(K7, 1);
    check("glitch_strobes", strobes - s0, 0);
    check("glitch_a", {a3, a2, a1, a0}, 16'h0123);
    key(K7, 10);
    check("hold_strobes", strobes - s0, 1);
    check("hold_a", {a3, a2, a1, a0}, 16'h0007);
    check("hold_valid", operands_valid, 1'b0);

    // overflow on the fifth digit, then clear
    tap(KCLR); tap(K9); tap(K8); tap(K7); tap(K6);
    s0 = strobes;
    tap(K5);
    check("ovf_strobe", strobes - s0, 1);
    check("ovf_a", {a3, a2, a1, a0}, 16'h9876);
    check("model_ovf", ma, 9876);
    tap(KCLR);
    check("clr_a", {a3, a2, a1, a0}, 16'h0000);
    check("clr_b", {b3, b2, b1, b0}, 16'h0000);
    check("clr_sel_b", sel_b, 1'b0);
    check("clr_valid", operands_valid, 1'b0);

    // digit in DONE starts a fresh A
    tap(K1); tap(K2); tap(KPLUS); tap(K3); tap(KEQ);
    check("done_valid", operands_valid, 1'b1);
    tap(K4);
    check("done_digit_a", {a3, a2, a1, a0}, 16'h0004);
    check("done_digit_b", {b3, b2, b1, b0}, 16'h0000);
    check("done_digit_valid", operands_valid, 1'b0);

    // reset while a key is mid-debounce
    @(negedge clk);
    pressed = K5;
    s0 = strobes;
    repeat (20) @(negedge clk);
    check("pre_rst_strobes", strobes - s0, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    s0 = strobes;
    repeat (31) @(negedge clk);
    check("post_rst_early", strobes - s0, 0);
    repeat (8) @(negedge clk);
    check("post_rst_press", strobes - s0, 1);
    check("post_rst_a", {a3, a2, a1, a0}, 16'h0005);
    pressed = -1;
    repeat (4 * FR) @(negedge clk);

    // '#' key
    tap(KCLR); tap(K1); tap(K2); tap(K3);
    s0 = strobes;
    tap(KHASH);
    check("hash_strobe", strobes - s0, 1);
`ifdef BCD_KEY_BACKSPACE_EN
    check("hash_a", {a3, a2, a1, a0}, 16'h0012);
`else
    check("hash_a", {a3, a2, a1, a0}, 16'h0123);
`endif

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
